// File: rtl/mem_handshake_responder.sv
// Fixed-latency memory responder with a four-phase request/response handshake.
// Services one read or write at a time against a word-addressed array.
module mem_handshake_responder #(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 inputReady,
  output logic                 ackOutput,
  output logic                 busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("LATENCY must be in 1..15");
    end
    if (ADDR_WIDTH > WORD_SIZE) begin : g_bad_addr
      $error("ADDR_WIDTH must not exceed WORD_SIZE");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic                  is_read;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_SIZE-1:0]  data;
  } req_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  req_t                   req;
  logic                   req_any;

  // Array powers up cleared; reset deliberately leaves contents alone.
  logic [WORD_SIZE-1:0]   mem [DEPTH] = '{default: '0};

  assign req_any = readM | writeM;

  // Upper address bits alias onto the array.
  generate
    if (WORD_SIZE > ADDR_WIDTH) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^address[WORD_SIZE-1:ADDR_WIDTH];
    end
  endgenerate

  // Handshake sequencer with registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      req        <= '0;
      rdata      <= '0;
      inputReady <= 1'b0;
      ackOutput  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_any) begin
            req.is_read <= readM;
            req.addr    <= address[ADDR_WIDTH-1:0];
            req.data    <= wdata;
            cnt         <= CNT_W'(LATENCY - 1);
            busy        <= 1'b1;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state <= S_RESP;
            if (req.is_read) begin
              inputReady <= 1'b1;
              rdata      <= mem[req.addr];
            end else begin
              ackOutput  <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          inputReady <= 1'b0;
          ackOutput  <= 1'b0;
          state      <= S_DONE;
        end
        S_DONE: begin
          if (!req_any) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write commits on the edge leaving RESP unless reset aborts it.
  always_ff @(posedge clk) begin
    if (!reset && state == S_RESP && !req.is_read) begin
      mem[req.addr] <= req.data;
    end
  end

endmodule
